reg_dec: RTL

- Down-counting companion to the incrementing address/PC register. It is the consumer-side loop/countdown register for each core.
- Software writes a count over the shared data bus. The core's control unit then decrements it once per iteration.
- The block reports zero, a one-cycle expiry pulse, and a sticky underflow error to the control unit.
- One instance per core; it sits on the same data bus and uses the same delayed write-enable timing as the incrementing register.

---
 rtl/reg_dec_pkg.sv | 15 +
 rtl/reg_dec_en_delay.sv | 18 +
 rtl/reg_dec.sv | 74 +++++++
 3 files changed

// File: rtl/reg_dec_pkg.sv
// Shared definitions for the decrementing loop/countdown register.
// The default width is common with the incrementing address register.
package reg_dec_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [DEFAULT_WIDTH-1:0] ZERO_COUNT = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        EXPIRED = 2'b10
    } state_t;

endpackage

// File: rtl/reg_dec_en_delay.sv
// One-flop delayed enable with synchronous active-low clear.
// The register write paths use it so that they share the same bus timing.
module en_delay (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic en_d
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en_d <= 1'b0;
        end else begin
            en_d <= en;
        end
    end

endmodule

// File: rtl/reg_dec.sv
// Down-counting loop register: the count is loaded from the shared bus one cycle after a write request.
// It reports zero, a one-cycle expiry pulse and a sticky underflow.
module reg_dec
    import reg_dec_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             reg_write_en,
    input  logic             reg_dec_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             done,
    output logic             underflow
);

    logic             wr_d;
    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             done_n;
    logic             underflow_n;

    en_delay u_en_delay (
        .clk  (clk),
        .rstn (rstn),
        .en   (reg_write_en),
        .en_d (wr_d)
    );

    // A decrement takes priority over a delayed load on the same edge.
    // In that case the load is dropped, which matches the incrementing register.
    always_comb begin
        state_n     = state;
        count_n     = data_out;
        done_n      = 1'b0;
        underflow_n = underflow;
        if (reg_dec_en) begin
            if (data_out != '0) begin
                count_n = data_out - 1'b1;
                if (data_out == WIDTH'(1)) begin
                    state_n = EXPIRED;
                    done_n  = 1'b1;
                end else begin
                    state_n = ARMED;
                end
            end else begin
                underflow_n = 1'b1;
            end
        end else if (wr_d) begin
            count_n     = data_in;
            underflow_n = 1'b0;
            state_n     = (data_in != '0) ? ARMED : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            data_out  <= '0;
            zero      <= 1'b1;
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            data_out  <= count_n;
            zero      <= (count_n == '0);
            done      <= done_n;
            underflow <= underflow_n;
        end
    end

endmodule
